// File: rtl/sync_debounce_ff.sv
// -----------------------------------------------------------------------------
// sync_debounce_ff
//
// Input conditioning stage ahead of the voted data flip-flop. An asynchronous,
// possibly bouncing level is synchronised into the c domain and then filtered.
// A new level is accepted only after DEBOUNCE_CYCLES consecutive enabled
// samples of that level. Shorter pulses are rejected.
//
// Ports:
//   c          in   clock, rising edge
//   rst_b      in   asynchronous active-low reset
//   din_async  in   raw asynchronous level
//   en         in   filter enable; 0 freezes the state machine and the counter.
//                   The synchroniser keeps sampling while en is 0.
//   d          out  debounced, synchronised level (registered)
//   rise       out  one-cycle strobe in the cycle d goes 0->1 (registered)
//   fall       out  one-cycle strobe in the cycle d goes 1->0 (registered)
//   busy       out  high while a level change is pending (registered)
//   glitch_cnt out  [7:0] saturating count of aborted pending changes.
//                   Present only when SYNC_DEBOUNCE_GLITCH_CNT_EN is defined.
//
// Optional feature macro: SYNC_DEBOUNCE_GLITCH_CNT_EN
// -----------------------------------------------------------------------------
module sync_debounce_ff #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic       c,
  input  logic       rst_b,
  input  logic       din_async,
  input  logic       en,
  output logic       d,
  output logic       rise,
  output logic       fall,
  output logic       busy
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
  ,
  output logic [7:0] glitch_cnt
`endif
);

  // Reject illegal configurations during elaboration.
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
    $error("sync_debounce_ff: SYNC_STAGES must be in 2..4");
  end
  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 255) begin : g_bad_debounce
    $error("sync_debounce_ff: DEBOUNCE_CYCLES must be in 2..255");
  end
  if ((2 ** CNT_W) <= DEBOUNCE_CYCLES) begin : g_bad_cnt_w
    $error("sync_debounce_ff: CNT_W too narrow for DEBOUNCE_CYCLES");
  end

  typedef enum logic [1:0] {
    STABLE_LO = 2'b00,
    PEND_HI   = 2'b01,
    STABLE_HI = 2'b10,
    PEND_LO   = 2'b11
  } state_t;

  // Entering a pending state already counts the first differing sample, so
  // acceptance happens when the counter reaches DEBOUNCE_CYCLES-1 and the
  // sample still differs.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   s_s;
  state_t                 state_r;
  logic [CNT_W-1:0]       cnt_r;

  assign s_s = sync_r[SYNC_STAGES-1];

  // Synchroniser chain; always clocked, independent of en.
  always_ff @(posedge c or negedge rst_b) begin
    if (!rst_b) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], din_async};
    end
  end

  // Filter state machine with registered level, strobes and busy flag.
  always_ff @(posedge c or negedge rst_b) begin
    if (!rst_b) begin
      state_r <= STABLE_LO;
      cnt_r   <= '0;
      d       <= 1'b0;
      rise    <= 1'b0;
      fall    <= 1'b0;
      busy    <= 1'b0;
    end else if (en) begin
      rise <= 1'b0;
      fall <= 1'b0;
      case (state_r)
        STABLE_LO: begin
          if (s_s) begin
            state_r <= PEND_HI;
            cnt_r   <= CNT_ONE;
            busy    <= 1'b1;
          end else begin
            state_r <= STABLE_LO;
            cnt_r   <= '0;
            busy    <= 1'b0;
          end
        end
        PEND_HI: begin
          if (!s_s) begin
            // Glitch rejected: back to the old level.
            state_r <= STABLE_LO;
            cnt_r   <= '0;
            busy    <= 1'b0;
          end else if (cnt_r == CNT_LAST) begin
            state_r <= STABLE_HI;
            cnt_r   <= '0;
            d       <= 1'b1;
            rise    <= 1'b1;
            busy    <= 1'b0;
          end else begin
            cnt_r   <= cnt_r + CNT_ONE;
            busy    <= 1'b1;
          end
        end
        STABLE_HI: begin
          if (!s_s) begin
            state_r <= PEND_LO;
            cnt_r   <= CNT_ONE;
            busy    <= 1'b1;
          end else begin
            state_r <= STABLE_HI;
            cnt_r   <= '0;
            busy    <= 1'b0;
          end
        end
        PEND_LO: begin
          if (s_s) begin
            state_r <= STABLE_HI;
            cnt_r   <= '0;
            busy    <= 1'b0;
          end else if (cnt_r == CNT_LAST) begin
            state_r <= STABLE_LO;
            cnt_r   <= '0;
            d       <= 1'b0;
            fall    <= 1'b1;
            busy    <= 1'b0;
          end else begin
            cnt_r   <= cnt_r + CNT_ONE;
            busy    <= 1'b1;
          end
        end
        default: begin
          // Unreachable encoding: fall back to the reset state.
          state_r <= STABLE_LO;
          cnt_r   <= '0;
          d       <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end else begin
      // Frozen: state, counter and level hold, strobes are suppressed.
      rise <= 1'b0;
      fall <= 1'b0;
    end
  end

`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
  logic abort_s;

  assign abort_s = en & (((state_r == PEND_HI) & ~s_s) |
                         ((state_r == PEND_LO) &  s_s));

  // Saturating count of aborted pending changes; cleared only by rst_b.
  always_ff @(posedge c or negedge rst_b) begin
    if (!rst_b) begin
      glitch_cnt <= 8'd0;
    end else if (abort_s && (glitch_cnt != 8'hFF)) begin
      glitch_cnt <= glitch_cnt + 8'd1;
    end else begin
      glitch_cnt <= glitch_cnt;
    end
  end
`else
  // Glitch counter not built in this configuration.
`endif

endmodule

// File: tb/tb_sync_debounce_ff.sv
// Self-checking bench for sync_debounce_ff (default parameters).
module tb_sync_debounce_ff;

  localparam int SS = 2;
  localparam int DC = 4;

  logic c;
  logic rst_b;
  logic din_async;
  logic en;
  logic d;
  logic rise;
  logic fall;
  logic busy;
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
  logic [7:0] glitch_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model: a delay line standing in for the synchroniser plus a
  // run length of consecutive enabled samples that differ from the level.
  logic m_dly [0:SS-1];
  logic m_d;
  logic m_rise;
  logic m_fall;
  int   m_run;
  int   m_glitch;

  sync_debounce_ff #(
    .SYNC_STAGES(SS),
    .DEBOUNCE_CYCLES(DC),
    .CNT_W(8)
  ) dut (
    .c(c),
    .rst_b(rst_b),
    .din_async(din_async),
    .en(en),
    .d(d),
    .rise(rise),
    .fall(fall),
    .busy(busy)
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
    ,
    .glitch_cnt(glitch_cnt)
`endif
  );

  initial c = 1'b0;
  always #5 c = ~c;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < SS; i++) m_dly[i] = 1'b0;
    m_d = 1'b0; m_rise = 1'b0; m_fall = 1'b0; m_run = 0; m_glitch = 0;
  endtask

  task automatic model_update(input logic dv, input logic ev);
    logic s;
    s = m_dly[SS-1];
    m_rise = 1'b0;
    m_fall = 1'b0;
    if (ev) begin
      if (s != m_d) begin
        m_run++;
        if (m_run == DC) begin
          m_d = s;
          if (s) m_rise = 1'b1;
          else   m_fall = 1'b1;
          m_run = 0;
        end
      end else begin
        if (m_run > 0 && m_glitch < 255) m_glitch++;
        m_run = 0;
      end
    end
    for (int i = SS - 1; i > 0; i--) m_dly[i] = m_dly[i-1];
    m_dly[0] = dv;
  endtask

  task automatic check_all();
    chk("d", int'(d), int'(m_d));
    chk("rise", int'(rise), int'(m_rise));
    chk("fall", int'(fall), int'(m_fall));
    chk("busy", int'(busy), (m_run > 0) ? 1 : 0);
    chk("rise_and_fall", int'(rise & fall), 0);
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
    chk("glitch_cnt", int'(glitch_cnt), m_glitch);
`endif
  endtask

  // Drive at the falling edge, update the model at the rising edge, compare
  // at the next falling edge.
  task automatic step(input logic dv, input logic ev);
    din_async = dv;
    en = ev;
    @(posedge c);
    model_update(dv, ev);
    @(negedge c);
    check_all();
  endtask

  initial begin
    int first_d;
    int first_busy;
    int n_rise;
    int n_fall;
    int saw_busy;
    int saw_d;
    int fall_ref;

    rst_b = 1'b0;
    din_async = 1'b0;
    en = 1'b1;
    model_reset();
    repeat (2) @(negedge c);
    check_all();
    rst_b = 1'b1;

    // Quiet input after reset release.
    for (int k = 0; k < 20; k++) step(1'b0, 1'b1);

    // Rising level held.
    first_d = -1; first_busy = -1; n_rise = 0; n_fall = 0;
    for (int k = 1; k <= 10; k++) begin
      step(1'b1, 1'b1);
      if (d && first_d < 0) first_d = k;
      if (busy && first_busy < 0) first_busy = k;
      n_rise += int'(rise);
      n_fall += int'(fall);
    end
    chk("rise_edge", first_d, 6);
    chk("busy_start_edge", first_busy, 3);
    chk("rise_pulses", n_rise, 1);
    chk("fall_pulses_on_rise", n_fall, 0);

    // Falling level held, en high throughout.
    fall_ref = -1; n_fall = 0;
    for (int k = 1; k <= 10; k++) begin
      step(1'b0, 1'b1);
      if (!d && fall_ref < 0) fall_ref = k;
      n_fall += int'(fall);
    end
    chk("fall_edge", fall_ref, 6);
    chk("fall_pulses", n_fall, 1);

    // Three-cycle pulse must be rejected.
    saw_busy = 0; saw_d = 0; n_rise = 0;
    for (int k = 1; k <= 13; k++) begin
      step((k <= 3) ? 1'b1 : 1'b0, 1'b1);
      saw_busy |= int'(busy);
      saw_d |= int'(d);
      n_rise += int'(rise);
    end
    chk("pulse_busy_seen", saw_busy, 1);
    chk("pulse_d_seen", saw_d, 0);
    chk("pulse_rise", n_rise, 0);
    chk("pulse_busy_end", int'(busy), 0);
    chk("model_glitch_after_pulse", m_glitch, 1);

    // Back to high.
    for (int k = 0; k < 10; k++) step(1'b1, 1'b1);

    // Falling level with en low for edges 4..8 (just after PEND_LO entry).
    first_d = -1; n_fall = 0;
    for (int k = 1; k <= 14; k++) begin
      step(1'b0, (k >= 4 && k <= 8) ? 1'b0 : 1'b1);
      if (!d && first_d < 0) first_d = k;
      n_fall += int'(fall);
    end
    chk("fall_edge_en_drop", first_d, fall_ref + 5);
    chk("fall_edge_en_drop_abs", first_d, 11);
    chk("fall_pulses_en_drop", n_fall, 1);

    // Reset while pending high with a count of 2.
    for (int k = 1; k <= 4; k++) step(1'b1, 1'b1);
    chk("pend_before_reset", int'(busy), 1);
    rst_b = 1'b0;
    model_reset();
    #1;
    chk("rst_d", int'(d), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_rise", int'(rise), 0);
    check_all();
    @(negedge c);
    check_all();
    rst_b = 1'b1;
    first_d = -1;
    for (int k = 1; k <= 10; k++) begin
      step(1'b1, 1'b1);
      if (d && first_d < 0) first_d = k;
    end
    chk("rise_edge_after_reset", first_d, 6);

    // Return low, then 300 single-sample glitches.
    for (int k = 0; k < 10; k++) step(1'b0, 1'b1);
    for (int g = 0; g < 300; g++) begin
      step(1'b1, 1'b1);
      step(1'b0, 1'b1);
    end
    for (int k = 0; k < 4; k++) step(1'b0, 1'b1);
    chk("model_glitch_sat", m_glitch, 255);
    chk("d_after_glitches", int'(d), 0);
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
    chk("glitch_cnt_sat", int'(glitch_cnt), 255);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
